// File: rtl/enemy_pkg.sv
// Shared types and default constants for the enemy inflation tracker.
package enemy_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLATED = 2'd1,
    POP      = 2'd2,
    DEAD     = 2'd3
  } inflate_state_t;

  localparam int unsigned MAX_LEVEL      = 4;
  localparam int unsigned DEFLATE_FRAMES = 30;
  localparam int unsigned POP_FRAMES     = 16;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/enemy_inflate_tracker_frame_counter.sv
// Saturating frame-tick counter with synchronous clear; never wraps.
module Frame_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             clear,
  input  logic             Frame_tick,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (Frame_tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/enemy_inflate_tracker.sv
// Enemy inflation FSM: pumps raise the level, MAX_LEVEL pops, POP times out to DEAD.
// Optional deflation over idle frames is enabled by defining ENEMY_DEFLATE_EN.
module enemy_inflate_tracker #(
  parameter int unsigned MAX_LEVEL      = enemy_pkg::MAX_LEVEL,
  parameter int unsigned DEFLATE_FRAMES = enemy_pkg::DEFLATE_FRAMES,
  parameter int unsigned POP_FRAMES     = enemy_pkg::POP_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Increment_pumped,
  input  logic       Frame_tick,
  input  logic       Enemy_active,
  output logic [2:0] Inflate_level,
  output logic       Enemy_frozen,
  output logic       Enemy_popped,
  output logic       Enemy_dead
);

  import enemy_pkg::*;

  localparam int unsigned CNT_MAX = max_u(DEFLATE_FRAMES, POP_FRAMES);
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  inflate_state_t state, nxt_state;
  logic [2:0]     level, nxt_level;
  logic           popped, nxt_popped;
  logic           cnt_clear;
  logic [CW-1:0]  count;
  logic           pop_expire;

  Frame_counter #(.WIDTH(CW)) u_cnt (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (cnt_clear),
    .Frame_tick (Frame_tick),
    .count      (count)
  );

  assign pop_expire = Frame_tick && (count == CW'(POP_FRAMES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      level  <= '0;
      popped <= 1'b0;
    end else begin
      state  <= nxt_state;
      level  <= nxt_level;
      popped <= nxt_popped;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_level  = level;
    nxt_popped = 1'b0;
    cnt_clear  = 1'b0;
    if (!Enemy_active) begin
      nxt_state = IDLE;
      nxt_level = '0;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        IDLE, INFLATED: begin
          if (Increment_pumped) begin
            // A pump always wins over a coincident deflate expiry.
            cnt_clear = 1'b1;
            if (level + 3'd1 >= 3'(MAX_LEVEL)) begin
              nxt_level  = 3'(MAX_LEVEL);
              nxt_state  = POP;
              nxt_popped = 1'b1;
            end else begin
              nxt_level = level + 3'd1;
              nxt_state = INFLATED;
            end
          end else if (state == IDLE) begin
            cnt_clear = 1'b1;
          end else begin
`ifdef ENEMY_DEFLATE_EN
            if (Frame_tick && (count == CW'(DEFLATE_FRAMES - 1))) begin
              cnt_clear = 1'b1;
              nxt_level = level - 3'd1;
              if (level == 3'd1) nxt_state = IDLE;
            end
`else
            cnt_clear = 1'b1;
`endif
          end
        end
        POP: begin
          nxt_level = 3'(MAX_LEVEL);
          if (pop_expire) begin
            nxt_state = DEAD;
            nxt_level = '0;
            cnt_clear = 1'b1;
          end
        end
        DEAD: begin
          nxt_level = '0;
          cnt_clear = 1'b1;
        end
        default: begin
          nxt_state = IDLE;
          nxt_level = '0;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  assign Inflate_level = level;
  assign Enemy_frozen  = (state == INFLATED) || (state == POP);
  assign Enemy_popped  = popped;
  assign Enemy_dead    = (state == DEAD);

endmodule

// File: tb/tb_enemy_inflate_tracker.sv
// Directed self-checking bench for enemy_inflate_tracker (default parameters).
module tb_enemy_inflate_tracker;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Increment_pumped;
  logic       Frame_tick;
  logic       Enemy_active;
  logic [2:0] Inflate_level;
  logic       Enemy_frozen;
  logic       Enemy_popped;
  logic       Enemy_dead;

  int checks   = 0;
  int failures = 0;

  enemy_inflate_tracker #(
    .MAX_LEVEL      (4),
    .DEFLATE_FRAMES (30),
    .POP_FRAMES     (16)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .Increment_pumped (Increment_pumped),
    .Frame_tick       (Frame_tick),
    .Enemy_active     (Enemy_active),
    .Inflate_level    (Inflate_level),
    .Enemy_frozen     (Enemy_frozen),
    .Enemy_popped     (Enemy_popped),
    .Enemy_dead       (Enemy_dead)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs, then sample 1ns after the edge.
  task automatic cyc(input logic p, input logic t);
    Increment_pumped = p;
    Frame_tick       = t;
    @(posedge Clk);
    #1;
    Increment_pumped = 1'b0;
    Frame_tick       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0;
    Increment_pumped = 1'b0;
    Frame_tick = 1'b0;
    Enemy_active = 1'b1;
    #3;
    check("rst_level",  Inflate_level, 0);
    check("rst_frozen", Enemy_frozen, 0);
    check("rst_popped", Enemy_popped, 0);
    check("rst_dead",   Enemy_dead, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(2);

    // Four pumps five cycles apart, pop, then 16 frames to DEAD
    cyc(1'b1, 1'b0); check("p1_level", Inflate_level, 1); check("p1_frozen", Enemy_frozen, 1);
    idle(4);
    cyc(1'b1, 1'b0); check("p2_level", Inflate_level, 2);
    idle(4);
    cyc(1'b1, 1'b0); check("p3_level", Inflate_level, 3); check("p3_popped", Enemy_popped, 0);
    idle(4);
    cyc(1'b1, 1'b0); check("p4_level", Inflate_level, 4); check("p4_popped", Enemy_popped, 1);
    idle(1);
    check("pop_pulse_end", Enemy_popped, 0);
    check("pop_frozen", Enemy_frozen, 1);
    cyc(1'b1, 1'b0); check("pop_pump_ignored", Inflate_level, 4);
    ticks(15);
    check("pop_15_dead", Enemy_dead, 0);
    check("pop_15_level", Inflate_level, 4);
    ticks(1);
    check("pop_16_dead", Enemy_dead, 1);
    check("dead_level", Inflate_level, 0);
    check("dead_frozen", Enemy_frozen, 0);

    // DEAD ignores pumps; leaves via Enemy_active low
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    check("dead_pumps_level", Inflate_level, 0);
    check("dead_pumps_dead", Enemy_dead, 1);
    Enemy_active = 1'b0;
    idle(1);
    Enemy_active = 1'b1;
    check("despawn_dead", Enemy_dead, 0);
    check("despawn_level", Inflate_level, 0);
    cyc(1'b1, 1'b0); check("respawn_pump", Inflate_level, 1);

    // One pump then 30 frames: deflates only when enabled
    ticks(29);
    check("defl_29_level", Inflate_level, 1);
    ticks(1);
`ifdef ENEMY_DEFLATE_EN
    check("defl_30_level", Inflate_level, 0);
    check("defl_30_frozen", Enemy_frozen, 0);
`else
    check("defl_30_level", Inflate_level, 1);
    check("defl_30_frozen", Enemy_frozen, 1);
`endif
    Enemy_active = 1'b0;
    idle(1);
    Enemy_active = 1'b1;
    check("clear_level", Inflate_level, 0);

    // Level 2, pump coincident with the 30th frame tick
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    check("l2_level", Inflate_level, 2);
    ticks(29);
    check("l2_29_level", Inflate_level, 2);
    cyc(1'b1, 1'b1);
    check("coinc_level", Inflate_level, 3);
    check("coinc_count", dut.u_cnt.count, 0);

    // Level 3, despawn for one cycle with a pump present
    Enemy_active = 1'b0;
    cyc(1'b1, 1'b0);
    Enemy_active = 1'b1;
    check("despawn3_level", Inflate_level, 0);
    check("despawn3_popped", Enemy_popped, 0);
    check("despawn3_frozen", Enemy_frozen, 0);
    idle(1);
    check("despawn3_popped2", Enemy_popped, 0);

    // Consecutive pumps saturate at MAX_LEVEL with a single pop pulse
    cyc(1'b1, 1'b0); cyc(1'b1, 1'b0); cyc(1'b1, 1'b0);
    check("burst3_level", Inflate_level, 3);
    cyc(1'b1, 1'b0);
    check("burst4_level", Inflate_level, 4);
    check("burst4_popped", Enemy_popped, 1);
    cyc(1'b1, 1'b0);
    check("burst5_level", Inflate_level, 4);
    check("burst5_popped", Enemy_popped, 0);

    // Reset mid-POP kills the pending DEAD transition
    ticks(5);
    #2;
    Reset_n = 1'b0;
    #1;
    check("popRst_level", Inflate_level, 0);
    check("popRst_frozen", Enemy_frozen, 0);
    check("popRst_popped", Enemy_popped, 0);
    check("popRst_dead", Enemy_dead, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    ticks(20);
    check("postRst_dead", Enemy_dead, 0);
    check("postRst_level", Inflate_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/enemy_inflate_tracker.md
ENEMY_INFLATE_TRACKER -- requirements
Module: Enemy_inflate_tracker

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 4: inflation level at which the enemy pops.
REQ-002 SHALL have parameter DEFLATE_FRAMES, default 30: frames without a pump before the level drops by one.
REQ-003 SHALL have parameter POP_FRAMES, default 16: frames the pop animation is held.
REQ-004 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port Increment_pumped  input  1  one-cycle pump pulse from the pump-state block.
REQ-007 SHALL have port Frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-008 SHALL have port Enemy_active  input  1  enemy is alive on the map; low means despawned.
REQ-009 SHALL have port Inflate_level  output  3  current inflation level, 0..MAX_LEVEL.
REQ-010 SHALL have port Enemy_frozen  output  1  high while level>0 or popping; the enemy must not move.
REQ-011 SHALL have port Enemy_popped  output  1  one-cycle pulse on entry to POP.
REQ-012 SHALL have port Enemy_dead  output  1  high in DEAD state.

Function
REQ-013 SHALL implement states IDLE, INFLATED, POP, DEAD.
REQ-014 IDLE: level 0; Increment_pumped -> level 1, INFLATED, next cycle.
REQ-015 INFLATED: each Increment_pumped increments the level by 1 and clears the frame counter.
REQ-016 INFLATED: a pump that takes the level to MAX_LEVEL -> POP next cycle, Enemy_popped high for exactly that one cycle.
REQ-017 INFLATED: a frame counter counts Frame_tick; on reaching DEFLATE_FRAMES it decrements the level and clears to 0; level 1->0 returns to IDLE.
REQ-018 A pump and a deflate expiry in the same cycle: the pump wins, no decrement, counter cleared.
REQ-019 POP: level held at MAX_LEVEL; pumps ignored; after POP_FRAMES Frame_ticks -> DEAD.
REQ-020 DEAD: level 0, Enemy_frozen low, pumps ignored; leaves only via Enemy_active low.
REQ-021 Enemy_active low in any state -> IDLE next cycle: level 0, counter 0, no Enemy_popped pulse.
REQ-022 Pumps while Enemy_active is low are ignored.
REQ-023 Pump pulses on consecutive cycles SHALL each count, saturating at MAX_LEVEL.
REQ-024 Frame counter width SHALL be $clog2(max(DEFLATE_FRAMES,POP_FRAMES)+1) and SHALL never wrap.

Reset
REQ-025 Reset_n low SHALL asynchronously force IDLE, level 0, counter 0, all outputs low.
REQ-026 Reset asserted during POP SHALL suppress any pending DEAD transition; the block resumes in IDLE after release.

Configuration
REQ-027 With ENEMY_DEFLATE_EN defined, REQ-017 deflation is active.
REQ-028 Without ENEMY_DEFLATE_EN, the level never decreases in INFLATED; only pumps, Enemy_active or reset change it, and the frame counter is used for POP timing only.

Structure
REQ-029 Shared package enemy_pkg SHALL hold the state enum (inflate_state_t) and default constants MAX_LEVEL, DEFLATE_FRAMES, POP_FRAMES.
REQ-030 The frame counter SHALL be a sub-module Frame_counter (inputs: clear, Frame_tick; output: count).

Verification
REQ-031 Four pumps 5 cycles apart from IDLE -> levels 1,2,3,4; Enemy_popped one cycle; 16 Frame_ticks later Enemy_dead=1.
REQ-032 One pump, then 30 Frame_ticks -> level 0, IDLE, Enemy_frozen=0 (ENEMY_DEFLATE_EN); same stimulus without the macro -> level stays 1.
REQ-033 Level 2; pump coincident with the 30th Frame_tick -> level 3, counter 0.
REQ-034 Level 3; Enemy_active low for 1 cycle -> level 0, IDLE, no Enemy_popped.
REQ-035 In POP, Reset_n low mid-count -> all outputs 0 immediately; after release, 20 Frame_ticks -> Enemy_dead stays 0.
REQ-036 In DEAD, 3 pumps -> level stays 0; Enemy_active low then high -> IDLE; 1 pump -> level 1.
